// File: rtl/mulu_xnyn_seq_if.sv
// mulu_xnyn_seq_if: request/result bundle for the sequential multiplier
// start/sgn/x/y: request (master drives); p/s/rdy/busy: result and status (slave drives)
interface mulu_xnyn_seq_if #(parameter int WIDTH = 4);
    logic               start;
    logic               sgn;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic [2*WIDTH-1:0] p;
    logic               s;
    logic               rdy;
    logic               busy;
    modport master (output start, sgn, x, y, input p, s, rdy, busy);
    modport slave  (input start, sgn, x, y, output p, s, rdy, busy);
endinterface

// File: rtl/mulu_xnyn_seq.sv
// mulu_xnyn_seq: shift-add multiplier, unsigned or two's complement, one multiplier bit per clock
// clk: clock; reset: synchronous active-low; bus: request (start/sgn/x/y) and result (p/s/rdy/busy)
module mulu_xnyn_seq #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mulu_xnyn_seq_if.slave        bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state, state_nx;
    logic [2*WIDTH-1:0] acc, mc, sum;
    logic [WIDTH-1:0]   mp, mx, my;
    logic [CW-1:0]      cnt;
    logic               neg, last, take;
    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mx   = (bus.sgn & bus.x[WIDTH-1]) ? -bus.x : bus.x;
        my   = (bus.sgn & bus.y[WIDTH-1]) ? -bus.y : bus.y;
        sum  = acc + (mp[0] ? mc : '0);
        last = cnt == CW'(WIDTH-1);
        take = (state != RUN) & bus.start;
    end
    always_ff @(posedge clk)
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = bus.start ? RUN : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.busy = state == RUN;
        bus.rdy  = state == DONE;
    end
    // The final partial product is folded in combinationally so p loads on the WIDTH-th RUN edge.
    always_ff @(posedge clk)
        if (!reset) begin
            acc   <= '0;
            mc    <= '0;
            mp    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            bus.p <= '0;
            bus.s <= 1'b0;
        end else if (take) begin
            acc <= '0;
            mc  <= {{WIDTH{1'b0}}, mx};
            mp  <= my;
            cnt <= '0;
            neg <= bus.sgn & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
        end else if (state == RUN) begin
            acc <= sum;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt + 1'b1;
            if (last) begin
                bus.p <= neg ? -sum : sum;
                bus.s <= neg & (|sum);
            end
        end
endmodule

// File: tb/tb_mulu_xnyn_seq.sv
// tb_mulu_xnyn_seq: directed vector table plus hand-written handshake corner sequences
module tb_mulu_xnyn_seq;
    localparam int W = 4;
    typedef struct {
        logic       sg;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] ep;
        logic       es;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    vec_t v[12];
    always #5 clk = ~clk;
    mulu_xnyn_seq_if #(.WIDTH(W)) bus();
    mulu_xnyn_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic go(input logic sg, input logic [3:0] a, input logic [3:0] b);
        bus.start = 1'b1;
        bus.sgn = sg;
        bus.x = a;
        bus.y = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic wait_rdy(output int lat, output int bb);
        lat = 0;
        bb = 0;
        while (!bus.rdy && lat < 12) begin
            if (!bus.busy) bb++;
            @(negedge clk);
            lat++;
        end
    endtask
    initial begin
        int lat, bb, rises;
        logic prev;
        v[0]  = '{1'b0, 4'hF, 4'hF, 8'hE1, 1'b0};
        v[1]  = '{1'b1, 4'h8, 4'h8, 8'h40, 1'b0};
        v[2]  = '{1'b1, 4'hD, 4'h5, 8'hF1, 1'b1};
        v[3]  = '{1'b1, 4'h9, 4'h0, 8'h00, 1'b0};
        v[4]  = '{1'b0, 4'h3, 4'h5, 8'h0F, 1'b0};
        v[5]  = '{1'b1, 4'h7, 4'h8, 8'hC8, 1'b1};
        v[6]  = '{1'b1, 4'hF, 4'hF, 8'h01, 1'b0};
        v[7]  = '{1'b0, 4'h8, 4'h8, 8'h40, 1'b0};
        v[8]  = '{1'b1, 4'h7, 4'h7, 8'h31, 1'b0};
        v[9]  = '{1'b0, 4'h0, 4'hF, 8'h00, 1'b0};
        v[10] = '{1'b1, 4'h0, 4'h8, 8'h00, 1'b0};
        v[11] = '{1'b1, 4'h1, 4'hF, 8'hFF, 1'b1};
        bus.start = 1'b1;
        bus.sgn = 1'b0;
        bus.x = 4'hF;
        bus.y = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset p", 32'(bus.p), 0);
        chk("reset s", 32'(bus.s), 0);
        chk("reset rdy", 32'(bus.rdy), 0);
        chk("reset busy over start", 32'(bus.busy), 0);
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            go(v[i].sg, v[i].a, v[i].b);
            wait_rdy(lat, bb);
            chk($sformatf("vec%0d latency", i), 32'(lat), 4);
            chk($sformatf("vec%0d busy gaps", i), 32'(bb), 0);
            chk($sformatf("vec%0d p", i), 32'(bus.p), 32'(v[i].ep));
            chk($sformatf("vec%0d s", i), 32'(bus.s), 32'(v[i].es));
            chk($sformatf("vec%0d busy in done", i), 32'(bus.busy), 0);
        end
        repeat (5) @(negedge clk);
        chk("done hold rdy", 32'(bus.rdy), 1);
        chk("done hold p", 32'(bus.p), 32'hFF);
        go(1'b0, 4'hF, 4'hF);
        bus.start = 1'b1;
        bus.x = 4'h1;
        bus.y = 4'h1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rdy && !prev) rises++;
            prev = bus.rdy;
        end
        chk("run ignore rdy rises", 32'(rises), 1);
        chk("run ignore p", 32'(bus.p), 32'hE1);
        chk("run ignore s", 32'(bus.s), 0);
        go(1'b0, 4'h3, 4'h5);
        chk("b2b rdy falls", 32'(bus.rdy), 0);
        chk("b2b busy", 32'(bus.busy), 1);
        chk("b2b p hold k", 32'(bus.p), 32'hE1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b p hold k+%0d", i), 32'(bus.p), 32'hE1);
        end
        @(negedge clk);
        chk("b2b rdy k+4", 32'(bus.rdy), 1);
        chk("b2b p k+4", 32'(bus.p), 32'h0F);
        go(1'b0, 4'hF, 4'hF);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort p", 32'(bus.p), 0);
        chk("abort s", 32'(bus.s), 0);
        chk("abort rdy", 32'(bus.rdy), 0);
        chk("abort busy", 32'(bus.busy), 0);
        reset = 1'b1;
        go(1'b1, 4'hD, 4'h5);
        wait_rdy(lat, bb);
        chk("post-reset latency", 32'(lat), 4);
        chk("post-reset p", 32'(bus.p), 32'hF1);
        chk("post-reset s", 32'(bus.s), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mulu_xnyn_seq.md
MULU_XNYN_SEQ -- requirements
Module: mulu_xnyn_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits; legal range 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request a new multiply; sampled only in IDLE or DONE.
REQ-005 SHALL have port sgn  input  1  operand mode for the request: 0 = unsigned, 1 = two's complement.
REQ-006 SHALL have port x  input  WIDTH  multiplicand; captured with start.
REQ-007 SHALL have port y  input  WIDTH  multiplier; captured with start.
REQ-008 SHALL have port p  output  2*WIDTH  product register.
REQ-009 SHALL have port s  output  1  product sign flag.
REQ-010 SHALL have port rdy  output  1  result valid.
REQ-011 SHALL have port busy  output  1  operation in progress.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1 at edge k, capture x, y and sgn, clear the accumulator and bit counter, and enter RUN.
REQ-014 SHALL, in RUN, process one multiplier bit per edge (shift-add, LSB first), for exactly WIDTH edges (k+1..k+WIDTH).
REQ-015 SHALL, at edge k+WIDTH, load p and s from the completed product and enter DONE; rdy=1 from that edge.
REQ-016 SHALL hold busy=1 exactly while in RUN; busy=0 in IDLE and DONE.
REQ-017 SHALL hold rdy=1 throughout DONE, and rdy=0 in IDLE and RUN.
REQ-018 SHALL hold p and s unchanged at all times except the DONE-entry edge and reset.
REQ-019 SHALL ignore start, x, y and sgn while in RUN; changes to them SHALL NOT affect the result in progress.
REQ-020 SHALL, on start in DONE, restart (back-to-back): RUN is entered at that edge and rdy falls.
REQ-021 SHALL remain in DONE indefinitely while start=0; there is no transition from DONE to IDLE except reset.
REQ-022 SHALL, for sgn=0, produce p = x*y as an unsigned 2*WIDTH-bit value, with s=0.
REQ-023 SHALL, for sgn=1, multiply operand magnitudes and negate the result if x[WIDTH-1]^y[WIDTH-1]=1, giving p = x*y as a 2*WIDTH-bit two's complement value.
REQ-024 SHALL handle the most-negative operand (-2^(WIDTH-1)) correctly; (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) SHALL be representable without overflow.
REQ-025 SHALL, for sgn=1, set s = p[2*WIDTH-1]; a zero product SHALL give s=0 regardless of operand signs.
REQ-026 SHALL give a multiply latency of WIDTH edges from the edge that samples start to the edge that asserts rdy, independent of operand values.

Reset
REQ-027 SHALL, on reset=0 at a rising edge, enter IDLE and set p=0, s=0, rdy=0, busy=0, accumulator=0 and counter=0.
REQ-028 SHALL, on reset during RUN, abort the operation; no partial result SHALL appear on p.
REQ-029 SHALL give reset priority over start on the same edge.
REQ-030 SHALL be ready to accept start on the first edge after reset returns to 1.

Verification (WIDTH=4)
REQ-031 SHALL cover: sgn=0, x=15, y=15 -> busy for 4 edges; rdy at edge k+4; p=0xE1; s=0.
REQ-032 SHALL cover: sgn=1, x=0x8 (-8), y=0x8 (-8) -> p=0x40, s=0.
REQ-033 SHALL cover: sgn=1, x=0xD (-3), y=0x5 -> p=0xF1 (-15), s=1; and sgn=1, x=0x9 (-7), y=0 -> p=0x00, s=0.
REQ-034 SHALL cover: start=1 with x=1, y=1 during RUN of 15*15 -> ignored; p=0xE1; exactly one rdy rise.
REQ-035 SHALL cover: start in DONE with unsigned 3*5 -> rdy falls the next edge; p holds 0xE1 until p=0x0F is loaded 4 edges later.
REQ-036 SHALL cover: reset=0 two edges into RUN -> IDLE, with p=0, s=0, rdy=0, busy=0; a new start afterwards completes correctly.
